// File: rtl/rename_free_list.sv
// Rename-stage RAT plus circular physical-register free list, 1-cycle rename latency, two retire frees per cycle.
// Optional double-free detection with an in-list bitmap when FREE_LIST_CHECK_EN is defined.
module rename_free_list #(
  parameter int NUM_PREG = 64,
  parameter int NUM_AREG = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rename_valid,
  output logic                          rename_ready,
  input  logic [$clog2(NUM_AREG)-1:0]   rd_arch,
  input  logic [$clog2(NUM_AREG)-1:0]   rs1_arch,
  input  logic [$clog2(NUM_AREG)-1:0]   rs2_arch,
  input  logic [31:0]                   instr_pc,
  output logic                          out_valid,
  output logic [31:0]                   out_pc,
  output logic [$clog2(NUM_PREG)-1:0]   dest_reg,
  output logic [$clog2(NUM_PREG)-1:0]   old_dest_reg,
  output logic [$clog2(NUM_PREG)-1:0]   src1_preg,
  output logic [$clog2(NUM_PREG)-1:0]   src2_preg,
  input  logic                          free_valid_1,
  input  logic [$clog2(NUM_PREG)-1:0]   free_preg_1,
  input  logic                          free_valid_2,
  input  logic [$clog2(NUM_PREG)-1:0]   free_preg_2,
`ifdef FREE_LIST_CHECK_EN
  output logic                          err_double_free,
`endif
  output logic [$clog2(NUM_PREG):0]     free_count
);

  localparam int PW = $clog2(NUM_PREG);
  localparam int CW = PW + 1;
  localparam int INIT_FREE = NUM_PREG - NUM_AREG;

  // Handshake: an instruction is taken at the edge where rename_valid && rename_ready;
  // rename_ready depends only on the registered free count.

  logic [PW-1:0] r_rat [NUM_AREG];
  logic [PW-1:0] r_fl  [NUM_PREG];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          r_out_valid;
  logic [31:0]   r_out_pc;
  logic [PW-1:0] r_dest;
  logic [PW-1:0] r_old_dest;
  logic [PW-1:0] r_src1;
  logic [PW-1:0] r_src2;

  logic          w_ready;
  logic          w_accept;
  logic          w_pop;
  logic [PW-1:0] w_popped;
  logic [CW-1:0] w_cnt_mid;
  logic          w_want1;
  logic          w_want2;
  logic          w_push1;
  logic          w_push2;
  logic [PW-1:0] w_tail2;
  logic [CW-1:0] w_cnt_after1;

  assign w_ready   = (r_count != '0);
  assign w_accept  = rename_valid && w_ready;
  assign w_pop     = w_accept && (rd_arch != '0);
  assign w_popped  = r_fl[r_head];
  assign w_cnt_mid = r_count - CW'(w_pop);

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREG-1:0] r_inlist;
  logic [NUM_PREG-1:0] w_inlist_nxt;
  logic                r_err;
  logic                w_dup1;
  logic                w_dup2;

  // Duplicates are judged against the pre-edge list contents, and slot 2 also against slot 1.
  assign w_dup1 = free_valid_1 && (free_preg_1 != '0) && r_inlist[free_preg_1];
  assign w_dup2 = free_valid_2 && (free_preg_2 != '0) &&
                  (r_inlist[free_preg_2] || (free_valid_1 && (free_preg_1 == free_preg_2)));
  assign w_want1 = free_valid_1 && (free_preg_1 != '0) && !w_dup1;
  assign w_want2 = free_valid_2 && (free_preg_2 != '0) && !w_dup2;

  always_comb begin
    w_inlist_nxt = r_inlist;
    if (w_pop)   w_inlist_nxt[w_popped]    = 1'b0;
    if (w_push1) w_inlist_nxt[free_preg_1] = 1'b1;
    if (w_push2) w_inlist_nxt[free_preg_2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++) r_inlist[i] <= (i >= NUM_AREG);
      r_err <= 1'b0;
    end else begin
      r_inlist <= w_inlist_nxt;
      r_err    <= r_err | w_dup1 | w_dup2;
    end
  end

  assign err_double_free = r_err;
`else
  assign w_want1 = free_valid_1 && (free_preg_1 != '0);
  assign w_want2 = free_valid_2 && (free_preg_2 != '0);
`endif

  // A full list drops pushes; slot 1 claims the last free entry before slot 2.
  assign w_push1      = w_want1 && (w_cnt_mid < CW'(NUM_PREG));
  assign w_cnt_after1 = w_cnt_mid + CW'(w_push1);
  assign w_push2      = w_want2 && (w_cnt_after1 < CW'(NUM_PREG));
  assign w_tail2      = w_push1 ? r_tail + PW'(1) : r_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) r_rat[i] <= PW'(i);
      for (int i = 0; i < NUM_PREG; i++)
        r_fl[i] <= (i < INIT_FREE) ? PW'(i + NUM_AREG) : '0;
      r_head      <= '0;
      r_tail      <= PW'(INIT_FREE);
      r_count     <= CW'(INIT_FREE);
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_dest      <= '0;
      r_old_dest  <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
    end else begin
      if (w_pop) begin
        r_rat[rd_arch] <= w_popped;
        r_head         <= r_head + PW'(1);
      end
      if (w_push1) r_fl[r_tail]  <= free_preg_1;
      if (w_push2) r_fl[w_tail2] <= free_preg_2;
      r_tail      <= r_tail + PW'(w_push1) + PW'(w_push2);
      r_count     <= w_cnt_after1 + CW'(w_push2);
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_pc   <= instr_pc;
        r_dest     <= w_pop ? w_popped : '0;
        r_old_dest <= w_pop ? r_rat[rd_arch] : '0;
        r_src1     <= r_rat[rs1_arch];
        r_src2     <= r_rat[rs2_arch];
      end
    end
  end

  assign rename_ready = w_ready;
  assign free_count   = r_count;
  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign dest_reg     = r_dest;
  assign old_dest_reg = r_old_dest;
  assign src1_preg    = r_src1;
  assign src2_preg    = r_src2;

endmodule

// File: tb/tb_rename_free_list.sv
// Self-checking bench for rename_free_list: directed steps, a reference RAT/free-list model and an expected-result queue.
module tb_rename_free_list;

  localparam int W = 56;

  logic        clk = 1'b0;
  logic        rst;
  logic        rename_valid;
  logic        rename_ready;
  logic [4:0]  rd_arch, rs1_arch, rs2_arch;
  logic [31:0] instr_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [5:0]  dest_reg, old_dest_reg, src1_preg, src2_preg;
  logic        free_valid_1, free_valid_2;
  logic [5:0]  free_preg_1, free_preg_2;
  logic [6:0]  free_count;
`ifdef FREE_LIST_CHECK_EN
  logic        err_double_free;
`endif

  always #5 clk = ~clk;

  rename_free_list dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_ready(rename_ready),
    .rd_arch(rd_arch), .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .instr_pc(instr_pc),
    .out_valid(out_valid), .out_pc(out_pc), .dest_reg(dest_reg), .old_dest_reg(old_dest_reg),
    .src1_preg(src1_preg), .src2_preg(src2_preg),
    .free_valid_1(free_valid_1), .free_preg_1(free_preg_1),
    .free_valid_2(free_valid_2), .free_preg_2(free_preg_2),
`ifdef FREE_LIST_CHECK_EN
    .err_double_free(err_double_free),
`endif
    .free_count(free_count)
  );

  // Reference model
  logic [5:0]   m_rat [32];
  int           m_fl [$];
  bit           m_in [64];
  logic         m_err;
  logic [W-1:0] m_last;
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = 6'(i);
    m_fl.delete();
    for (int i = 32; i < 64; i++) m_fl.push_back(i);
    for (int i = 0; i < 64; i++) m_in[i] = (i >= 32);
    exp_q.delete();
    m_err  = 1'b0;
    m_last = '0;
  endtask

  task automatic idle_inputs();
    rename_valid = 0; rd_arch = 0; rs1_arch = 0; rs2_arch = 0; instr_pc = 0;
    free_valid_1 = 0; free_preg_1 = 0; free_valid_2 = 0; free_preg_2 = 0;
  endtask

  task automatic check_outputs();
    chk("free_count", free_count, m_fl.size());
    chk("ready", rename_ready, m_fl.size() != 0);
    chk("outputs_hold", {out_pc, dest_reg, old_dest_reg, src1_preg, src2_preg}, m_last);
`ifdef FREE_LIST_CHECK_EN
    chk("err_double_free", err_double_free, m_err);
`endif
  endtask

  // Reset with busy inputs held high to show in-flight work is discarded.
  task automatic do_reset();
    rst = 1;
    rename_valid = 1; rd_arch = 9; rs1_arch = 3; rs2_arch = 4; instr_pc = 32'hdead_beef;
    free_valid_1 = 1; free_preg_1 = 6'd12; free_valid_2 = 1; free_preg_2 = 6'd13;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    check_outputs();
  endtask

  task automatic model_free(input logic fv, input logic [5:0] p, input logic dup);
    if (!fv || p == 0) return;
`ifdef FREE_LIST_CHECK_EN
    if (dup) begin m_err = 1'b1; return; end
`endif
    if (m_fl.size() < 64) begin
      m_fl.push_back(p);
      m_in[p] = 1;
    end
  endtask

  task automatic step(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic f1, input logic [5:0] p1, input logic f2, input logic [5:0] p2);
    logic acc;
    logic [5:0] d, o, s1, s2;
    logic dup1, dup2;
    logic [W-1:0] e;
    bit pre_in [64];
    rename_valid = v; rd_arch = rd; rs1_arch = rs1; rs2_arch = rs2; instr_pc = $urandom;
    free_valid_1 = f1; free_preg_1 = p1; free_valid_2 = f2; free_preg_2 = p2;
    pre_in = m_in;
    acc = v && (m_fl.size() != 0);
    if (acc) begin
      s1 = m_rat[rs1];
      s2 = m_rat[rs2];
      if (rd != 0) begin
        d = 6'(m_fl.pop_front());
        o = m_rat[rd];
        m_rat[rd] = d;
        m_in[d] = 0;
      end else begin
        d = 0; o = 0;
      end
      exp_q.push_back({instr_pc, d, o, s1, s2});
    end
    dup1 = pre_in[p1];
    dup2 = pre_in[p2] || (f1 && p1 == p2);
    model_free(f1, p1, dup1);
    model_free(f2, p2, dup2);
    @(posedge clk); #1;
    chk("out_valid", out_valid, acc);
    if (acc && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_last = e;
      chk("rename_result", {out_pc, dest_reg, old_dest_reg, src1_preg, src2_preg}, e);
    end
    check_outputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    do_reset();
    chk("reset_count", free_count, 7'd32);
    chk("reset_ready", rename_ready, 1'b1);

    // Basic rename and back-to-back RAT chaining
    step(1, 5, 5, 6, 0, 0, 0, 0);
    chk("b2b1_dest", dest_reg, 6'd32);
    chk("b2b1_old", old_dest_reg, 6'd5);
    chk("b2b1_src1", src1_preg, 6'd5);
    chk("b2b1_src2", src2_preg, 6'd6);
    chk("b2b1_count", free_count, 7'd31);
    step(1, 5, 5, 6, 0, 0, 0, 0);
    chk("b2b2_dest", dest_reg, 6'd33);
    chk("b2b2_old", old_dest_reg, 6'd32);
    chk("b2b2_src1", src1_preg, 6'd32);
    step(0, 7, 1, 2, 0, 0, 0, 0);

    // Drain the free list
    for (int i = 0; i < 30; i++)
      step(1, 5'(1 + (i % 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, 0, 0, 0);
    chk("empty_count", free_count, 7'd0);
    chk("empty_ready", rename_ready, 1'b0);
    step(1, 7, 7, 7, 0, 0, 0, 0);
    // Frees arriving while empty do not make this cycle ready
    step(1, 8, 8, 8, 1, 6'd40, 1, 6'd41);
    chk("refill_count", free_count, 7'd2);
    step(1, 3, 7, 8, 0, 0, 0, 0);
    chk("realloc_40", dest_reg, 6'd40);
    step(1, 4, 3, 4, 0, 0, 0, 0);
    chk("realloc_41", dest_reg, 6'd41);

    // x0 destination and free of preg 0
    step(0, 0, 0, 0, 1, 6'd50, 1, 6'd0);
    step(1, 0, 0, 7, 0, 0, 0, 0);
    chk("x0_dest", dest_reg, 6'd0);
    chk("x0_old", old_dest_reg, 6'd0);
    chk("x0_src1", src1_preg, 6'd0);
    chk("x0_count", free_count, 7'd1);

    // Random mix of renames and frees
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));

    // Push toward a full list to exercise saturation
    for (int i = 0; i < 40; i++)
      step(0, 0, 0, 0, 1, 6'($urandom_range(1, 63)), 1, 6'($urandom_range(1, 63)));
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 1, 6'($urandom_range(1, 63)), 1, 6'($urandom_range(1, 63)));

    // Reset mid-operation, then free 45 through both slots
    do_reset();
    for (int i = 0; i < 14; i++) step(1, 5'(i + 1), 0, 0, 0, 0, 0, 0);
    chk("pre_double_count", free_count, 7'd18);
    step(0, 0, 0, 0, 1, 6'd45, 1, 6'd45);
`ifdef FREE_LIST_CHECK_EN
    chk("double_free_err", err_double_free, 1'b1);
    chk("double_free_count", free_count, 7'd19);
`else
    chk("double_free_count", free_count, 7'd20);
`endif
    step(1, 20, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_free_list.md
Name: rename_free_list

Overview:
- Rename-stage register allocator that feeds the reorder buffer at dispatch; it sits between decode and the ROB.
- Holds the architectural-to-physical map (RAT, 32 entries) and a circular free list of physical registers.
- Each renamed instruction gets a new destination physical register, its old mapping and both source mappings.
- The ROB returns old destination registers on retire; this block recycles them, up to 2 per cycle.

Parameters:
- NUM_PREG, 64, number of physical registers; also the free-list depth.
- NUM_AREG, 32, number of architectural registers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rename_valid  in  1  instruction presented for rename
- rename_ready  out  1  free list non-empty; an instruction is accepted only when rename_valid && rename_ready
- rd_arch  in  5  architectural destination
- rs1_arch  in  5  architectural source 1
- rs2_arch  in  5  architectural source 2
- instr_pc  in  32  PC of the instruction being renamed
- out_valid  out  1  registered rename result valid
- out_pc  out  32  PC of the renamed instruction
- dest_reg  out  6  newly allocated physical destination
- old_dest_reg  out  6  previous mapping of rd_arch
- src1_preg  out  6  physical source 1
- src2_preg  out  6  physical source 2
- free_valid_1  in  1  retire-side free, slot 1
- free_preg_1  in  6  physical register freed, slot 1
- free_valid_2  in  1  retire-side free, slot 2
- free_preg_2  in  6  physical register freed, slot 2
- free_count  out  7  entries currently in the free list (0..64)

Behaviour:
- Reset (rst high at a clk edge):
  - RAT[i] = i for i = 0..31.
  - Free list holds pregs 32..63 in order; head = 0, tail = 32, free_count = 32.
  - out_valid = 0; out_pc, dest_reg, old_dest_reg, src1_preg and src2_preg all = 0.
  - Reset mid-operation discards in-flight results and pending frees in that cycle.
- rename_ready = (free_count != 0). It depends on state only, never on current inputs.
- Accept condition: rename_valid && rename_ready.
- Accept with rd_arch != 0:
  - Pop free_list[head]; head increments modulo 64.
  - Outputs one cycle later: dest_reg = popped preg, old_dest_reg = RAT[rd_arch], src1_preg = RAT[rs1_arch], src2_preg = RAT[rs2_arch], all read before this cycle's update.
  - RAT[rd_arch] takes the popped preg at the same edge.
- Accept with rd_arch == 0: no pop, no RAT write; dest_reg = 0, old_dest_reg = 0, sources looked up normally. x0 always maps to preg 0.
- Read-before-write: if rs1_arch or rs2_arch equals rd_arch in the same instruction, the source gets the old mapping.
- Back-to-back accepts see the RAT as updated by the previous edge, so no separate bypass is needed.
- Latency is 1 cycle. out_valid is 1 in the cycle after an accept, 0 otherwise. Outputs hold their last values while out_valid = 0.
- No accept: no RAT or free-list change; out_valid = 0 next cycle.
- Frees:
  - Each valid slot pushes its preg at tail; tail increments modulo 64.
  - Slot 1 is pushed before slot 2.
  - preg 0 is never pushed; a free of 0 is ignored.
- Same-cycle free and allocate:
  - The allocate pops from the pre-edge head.
  - A register freed this cycle is not allocatable until the next cycle.
  - If the list is empty, rename_ready stays 0 this cycle even when frees arrive.
- free_count next = free_count − pop + pushes.
- Full list (free_count == 64): further pushes in that cycle are dropped and free_count saturates at 64; slot 1 takes priority over slot 2.
- Pointers are 6-bit and wrap from 63 to 0.

Optional Feature:
- Macro: FREE_LIST_CHECK_EN.
- When defined:
  - Adds output err_double_free (1 bit, sticky, reset 0).
  - A 64-bit in-list bitmap is kept: set on push, cleared on pop.
  - err_double_free is set at the edge when a free names a preg already in the list, or both slots name the same preg.
  - The offending push is dropped.
- When undefined: no bitmap and no port. Double frees are pushed as normal, subject to the full-list drop rule.

Test Plan:
- Reset, then idle → rename_ready = 1, free_count = 32, out_valid = 0, RAT identity (rd=5 maps to 5).
- Accept rd=5, rs1=5, rs2=6 → next cycle out_valid = 1, dest_reg = 32, old_dest_reg = 5, src1_preg = 5, src2_preg = 6, free_count = 31.
- Second back-to-back accept, rd=5, rs1=5 → dest_reg = 33, old_dest_reg = 32, src1_preg = 32.
- Accept 32 instructions with rd=1..31 cycling → free_count = 0, rename_ready = 0. A 33rd valid is not accepted: out_valid = 0, RAT unchanged.
- From empty, free_valid_1 = 1 with preg 40 and free_valid_2 = 1 with preg 41 in the same cycle → next cycle free_count = 2, rename_ready = 1. Next two allocations return 40 then 41.
- Accept rd=0, rs1=0 → dest_reg = 0, old_dest_reg = 0, src1_preg = 0, free_count unchanged. With FREE_LIST_CHECK_EN, freeing 45 twice → err_double_free = 1 and free_count increments once.
